// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit:
// next-PC select codes and controller states.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_BR   = 2'b01,
    SEL_JABS = 2'b10,
    SEL_JREG = 2'b11
  } sel_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch
// controller (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             ena;
  logic [1:0]       sel;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jtarget;
  logic [WIDTH-1:0] jreg;
  logic             exc_req;
  logic             eret;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] epc;
  logic             halted;
  logic             misalign;

  modport master (
    output ena, sel, br_off, jtarget, jreg,
    output exc_req, eret, halt_req, resume,
    input  pc, pc_plus, epc, halted, misalign
  );

  modport slave (
    input  ena, sel, br_off, jtarget, jreg,
    input  exc_req, eret, halt_req, resume,
    output pc, pc_plus, epc, halted, misalign
  );
endinterface

// File: rtl/pc_unit_en_reg.sv
// Enabled register with asynchronous active-high
// reset to zero; holds the saved exception PC.
module en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // capture d when enabled, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump select,
// exception/eret, halt/resume and misalign trap.
module pc_unit
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC =
    WIDTH'(32'h0040_0000),
  parameter logic [WIDTH-1:0] EXC_VEC =
    WIDTH'(32'h0040_0004),
  parameter int INC = 4
) (
  input  logic clk,
  input  logic rst,
  pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] epc;
  state_t           state;
  logic             halted_r;
  logic             mis_r;
  logic             run;
  logic             adv;
  logic             bad;
  logic             epc_en;

  assign pc_plus = pc_r + WIDTH'(INC);
  assign run     = (state == ST_RUN);

  // a normal advance: running, enabled, nothing
  // of higher priority pending this edge
  assign adv = run & bus.ena & ~bus.exc_req
             & ~bus.eret & ~bus.halt_req;
  assign bad = |cand[1:0];

  // epc records the PC being left on a trap
  assign epc_en = bus.exc_req | (adv & bad);

  // next-PC candidate from the select code
  always_comb begin
    cand = pc_plus;
    unique case (sel_t'(bus.sel))
      SEL_SEQ:  cand = pc_plus;
      SEL_BR:   cand = pc_plus + bus.br_off;
      SEL_JABS: cand = bus.jtarget;
      SEL_JREG: cand = bus.jreg;
    endcase
  end

  // run/halt controller, PC and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r     <= RESET_VEC;
      state    <= ST_RUN;
      halted_r <= 1'b0;
      mis_r    <= 1'b0;
    end else begin
      mis_r <= 1'b0;
      if (bus.exc_req) begin
        pc_r     <= EXC_VEC;
        state    <= ST_RUN;
        halted_r <= 1'b0;
      end else if (bus.eret) begin
        pc_r     <= epc;
        state    <= ST_RUN;
        halted_r <= 1'b0;
      end else if (run && bus.halt_req) begin
        state    <= ST_HALT;
        halted_r <= 1'b1;
      end else if (!run && bus.resume) begin
        state    <= ST_RUN;
        halted_r <= 1'b0;
      end else if (adv) begin
        if (bad) begin
          pc_r  <= EXC_VEC;
          mis_r <= 1'b1;
        end else begin
          pc_r <= cand;
        end
      end
    end
  end

  en_reg #(
    .WIDTH(WIDTH)
  ) u_epc (
    .clk(clk),
    .rst(rst),
    .en (epc_en),
    .d  (pc_r),
    .q  (epc)
  );

  assign bus.pc       = pc_r;
  assign bus.pc_plus  = pc_plus;
  assign bus.epc      = epc;
  assign bus.halted   = halted_r;
  assign bus.misalign = mis_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios
// plus randomized traffic against a reference model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_halt;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(8))  b8 ();

  pc_unit #(
    .WIDTH(32),
    .RESET_VEC(RV),
    .EXC_VEC(EV),
    .INC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pc_unit #(
    .WIDTH(8),
    .RESET_VEC(8'hF4),
    .EXC_VEC(8'h04),
    .INC(4)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // monitor: outputs are valid every cycle, compare
  // against the oldest outstanding expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_pc", bus.pc, e.pc);
      chk("sb_epc", bus.epc, e.epc);
      chk("sb_halted", {31'b0, bus.halted},
          {31'b0, e.halted});
      chk("sb_misalign", {31'b0, bus.misalign},
          {31'b0, e.mis});
      chk("sb_pc_plus", bus.pc_plus, e.pc + 32'd4);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.ena = 0; bus.sel = 0; bus.br_off = 0;
    bus.jtarget = 0; bus.jreg = 0;
    bus.exc_req = 0; bus.eret = 0;
    bus.halt_req = 0; bus.resume = 0;
  endtask

  // drive one cycle of stimulus and predict the
  // architectural state after the following edge
  task automatic step(input logic en,
                      input logic [1:0] s,
                      input logic [31:0] bo,
                      input logic [31:0] jt,
                      input logic [31:0] jr,
                      input logic ex, er, hr, rs);
    logic [31:0] t;
    logic        mis;
    @(negedge clk);
    bus.ena = en; bus.sel = s; bus.br_off = bo;
    bus.jtarget = jt; bus.jreg = jr;
    bus.exc_req = ex; bus.eret = er;
    bus.halt_req = hr; bus.resume = rs;
    mis = 1'b0;
    if (ex) begin
      m_epc = m_pc; m_pc = EV; m_halt = 1'b0;
    end else if (er) begin
      m_pc = m_epc; m_halt = 1'b0;
    end else if (!m_halt && hr) begin
      m_halt = 1'b1;
    end else if (m_halt && rs) begin
      m_halt = 1'b0;
    end else if (!m_halt && en) begin
      case (s)
        2'd0:    t = m_pc + 4;
        2'd1:    t = m_pc + 4 + bo;
        2'd2:    t = jt;
        default: t = jr;
      endcase
      if (t % 4 != 0) begin
        m_epc = m_pc; m_pc = EV; mis = 1'b1;
      end else begin
        m_pc = t;
      end
    end
    q.push_back('{m_pc, m_epc, m_halt, mis});
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic seq();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jabs(input logic [31:0] t);
    step(1, 2, 0, t, 0, 0, 0, 0, 0);
  endtask

  // async reset mid-cycle, then held across an edge
  // where every other event is also requested
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_pc", bus.pc, RV);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);
    chk("rst_misalign", {31'b0, bus.misalign}, 32'h0);
    @(negedge clk);
    bus.exc_req = 1; bus.eret = 1;
    bus.ena = 1; bus.halt_req = 1;
    @(posedge clk);
    #1;
    chk("rst_ovr_pc", bus.pc, RV);
    chk("rst_ovr_epc", bus.epc, 32'h0);
    chk("rst_ovr_halted", {31'b0, bus.halted}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    m_pc = RV; m_epc = 32'h0; m_halt = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    b8.ena = 0; b8.sel = 0; b8.br_off = 0;
    b8.jtarget = 0; b8.jreg = 0;
    b8.exc_req = 0; b8.eret = 0;
    b8.halt_req = 0; b8.resume = 0;
    m_pc = RV; m_epc = 0; m_halt = 0;

    do_reset();

    // 8-bit instance: sequential wrap past 0xFC
    chk("w8_reset", {24'b0, b8.pc}, 32'hF4);
    @(negedge clk);
    b8.ena = 1;
    after_edge();
    chk("w8_f8", {24'b0, b8.pc}, 32'hF8);
    after_edge();
    chk("w8_fc", {24'b0, b8.pc}, 32'hFC);
    chk("w8_plus_wrap", {24'b0, b8.pc_plus}, 32'h00);
    after_edge();
    chk("w8_wrap", {24'b0, b8.pc}, 32'h00);
    b8.ena = 0;

    // sequential from reset
    seq(); after_edge();
    chk("seq1", bus.pc, 32'h0040_0004);
    seq(); after_edge();
    chk("seq2", bus.pc, 32'h0040_0008);
    seq(); after_edge();
    chk("seq3", bus.pc, 32'h0040_000C);

    // branch backwards and register jump
    seq(); after_edge();
    chk("pre_br", bus.pc, 32'h0040_0010);
    step(1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("branch", bus.pc, 32'h0040_0004);
    step(1, 3, 0, 0, 32'h0040_1000, 0, 0, 0, 0);
    after_edge();
    chk("jreg", bus.pc, 32'h0040_1000);

    // misaligned absolute jump traps
    jabs(32'h0040_0020);
    jabs(32'h0040_0002); after_edge();
    chk("mis_pc", bus.pc, EV);
    chk("mis_epc", bus.epc, 32'h0040_0020);
    chk("mis_flag", {31'b0, bus.misalign}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0); after_edge();
    chk("mis_pulse", {31'b0, bus.misalign}, 32'h0);

    // exception with ena low, then return
    jabs(32'h0040_0100);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0); after_edge();
    chk("exc_pc", bus.pc, EV);
    chk("exc_epc", bus.epc, 32'h0040_0100);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0); after_edge();
    chk("eret_pc", bus.pc, 32'h0040_0100);

    // halt freezes pc, resume then advance
    jabs(32'h0040_0008);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0); after_edge();
    chk("halt_flag", {31'b0, bus.halted}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      seq(); after_edge();
      chk("halt_hold", bus.pc, 32'h0040_0008);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 1); after_edge();
    chk("resume_pc", bus.pc, 32'h0040_0008);
    seq(); after_edge();
    chk("resume_adv", bus.pc, 32'h0040_000C);

    // reset while halted
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bo, jt, jr;
      bo = $urandom;
      jt = $urandom;
      jr = $urandom;
      if ($urandom_range(3) != 0) bo[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jr[1:0] = 2'b00;
      step($urandom_range(3) != 0,
           2'($urandom_range(3)), bo, jt, jr,
           $urandom_range(15) == 0,
           $urandom_range(15) == 0,
           $urandom_range(11) == 0,
           $urandom_range(3) == 0);
    end

    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drain", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/datapath width (>=8).
REQ-002 SHALL have parameter RESET_VEC, default 32'h0040_0000, PC value after reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0040_0004, exception/misalign target.
REQ-004 SHALL have parameter INC, default 4, sequential increment.
REQ-005 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ena  in  1  advance enable; 0 = stall, PC holds.
REQ-008 SHALL have port sel  in  2  next-PC mode: 00 seq, 01 branch, 10 jump abs, 11 jump reg.
REQ-009 SHALL have port br_off  in  WIDTH  signed byte offset, added to pc_plus.
REQ-010 SHALL have port jtarget  in  WIDTH  absolute jump target.
REQ-011 SHALL have port jreg  in  WIDTH  register jump target.
REQ-012 SHALL have port exc_req  in  1  exception request.
REQ-013 SHALL have port eret  in  1  return from exception.
REQ-014 SHALL have port halt_req / resume  in  1 each  enter / leave HALT.
REQ-015 SHALL have port pc  out  WIDTH  current PC (registered).
REQ-016 SHALL have port pc_plus  out  WIDTH  pc + INC, combinational, wraps mod 2^WIDTH.
REQ-017 SHALL have port epc  out  WIDTH  saved exception PC (registered).
REQ-018 SHALL have port halted / misalign  out  1 each  HALT-state flag / one-cycle misalign pulse.

Function
REQ-019 SHALL implement FSM states RUN, HALT; HALT holds pc regardless of ena/sel.
REQ-020 SHALL apply per-edge priority: exc_req > eret > halt_req (RUN only) > resume (HALT only) > ena update.
REQ-021 exc_req (any state, ena ignored) SHALL load pc<=EXC_VEC, epc<=pc, state<=RUN, in one cycle.
REQ-022 eret (no exc_req, ena ignored) SHALL load pc<=epc, epc unchanged, state<=RUN.
REQ-023 halt_req in RUN SHALL hold pc and enter HALT next edge; halted=1 while in HALT.
REQ-024 resume in HALT SHALL return to RUN; pc unchanged that edge, advancing from next edge.
REQ-025 In RUN with ena=1, pc SHALL load candidate: seq pc_plus; branch pc_plus+br_off; jump abs jtarget; jump reg jreg.
REQ-026 All adds SHALL be WIDTH-bit modulo (wrap-around, no carry out).
REQ-027 Candidate with bits[1:0]!=0 SHALL NOT load; instead pc<=EXC_VEC, epc<=pc, misalign=1 for exactly one cycle.
REQ-028 misalign SHALL be evaluated only when ena=1 in RUN with no higher-priority event.
REQ-029 ena=0 in RUN SHALL hold pc, epc, state; misalign=0.
REQ-030 Latency: new pc visible one cycle after the sampling edge; no bubbles.

Reset
REQ-031 rst SHALL asynchronously force pc=RESET_VEC, epc=0, state=RUN, halted=0, misalign=0.
REQ-032 rst SHALL override every other input, including mid-HALT and same-cycle exc_req.
REQ-033 First advance SHALL occur on the first rising edge after rst deasserts with ena=1.

Structure
REQ-034 SHALL place sel encodings (SEL_SEQ/BR/JABS/JREG) and FSM state encodings in shared package pc_pkg.
REQ-035 SHALL instantiate one sub-module en_reg (WIDTH-param, async-reset, enabled register) for epc.
REQ-036 Next-PC candidate mux and alignment check SHALL be combinational inside pc_unit.

Verification
REQ-037 Reset/seq: rst pulse, ena=1 sel=00 for 3 edges -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-038 Branch/jumps: pc=0x00400010, sel=01 br_off=0xFFFFFFF0 -> 0x00400004; sel=11 jreg=0x00401000 -> 0x00401000.
REQ-039 Misalign: sel=10 jtarget=0x00400002 at pc=0x00400020 -> pc=0x00400004, epc=0x00400020, misalign high one cycle.
REQ-040 Exception/eret: exc_req at pc=0x00400100 with ena=0 -> pc=0x00400004, epc=0x00400100; eret -> pc=0x00400100.
REQ-041 Halt: halt_req at pc=0x00400008 -> halted=1, pc frozen 5 cycles with ena=1; resume -> next edge pc=0x0040000C.
REQ-042 Wrap/reset mid-op: WIDTH=8, pc=0xFC seq -> 0x00; async rst mid-cycle during HALT -> pc=RESET_VEC immediately, halted=0.
